// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Oversampling UART receiver. A frame is a start bit (0), WIDTH data bits
//   sent LSB first, an optional parity bit and a stop bit (1). Each bit lasts
//   P clock cycles, where P is the captured oversampling ratio (8, 16 or 32).
//   The bit value is the majority of three samples taken around mid-bit. Once
//   the stop bit has been evaluated, a one-cycle result pulse is produced.
//
// Ports
//   i_clk         oversampling clock, one cycle per sample tick
//   i_rst         synchronous active-high reset
//   i_rx_in       serial line, idle high, already synchronised to i_clk
//   i_prescale    oversampling ratio (8/16/32; anything else acts as 8)
//   i_par_en      1 = parity bit present between data and stop
//   i_par_typ     0 = even parity, 1 = odd parity
//   o_p_data      last correctly received word, bit 0 = first data bit
//   o_data_valid  one-cycle pulse, o_p_data holds a new good frame
//   o_par_err     one-cycle pulse, parity mismatch in the frame just ended
//   o_stp_err     one-cycle pulse, stop bit sampled as 0
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx_in,
  input  logic [5:0]       i_prescale,
  input  logic             i_par_en,
  input  logic             i_par_typ,
  output logic [WIDTH-1:0] o_p_data,
  output logic             o_data_valid,
  output logic             o_par_err,
  output logic             o_stp_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_nextState;
  logic [5:0]       r_edgeCnt;
  logic [BW-1:0]    r_bitCnt;
  logic [5:0]       r_prescale;
  logic             r_parEn;
  logic             r_parTyp;
  logic [2:0]       r_samples;
  logic [WIDTH-1:0] r_shift;
  logic             r_parErr;

  logic [5:0]       w_halfP;
  logic [5:0]       w_capPrescale;
  logic             w_inWindow;
  logic             w_lastEdge;
  logic             w_lastDataBit;
  logic             w_bit;
  logic             w_detect;
  logic             w_parityBad;

  // The sampling window is the three edges centred on mid-bit; the decision
  // for every bit is taken at the last edge of the bit, by which time all
  // three samples of that bit have been shifted in.
  assign w_halfP       = {1'b0, r_prescale[5:1]};
  assign w_inWindow    = (r_edgeCnt == w_halfP - 6'd1) ||
                         (r_edgeCnt == w_halfP) ||
                         (r_edgeCnt == w_halfP + 6'd1);
  assign w_lastEdge    = (r_edgeCnt == r_prescale - 6'd1);
  assign w_lastDataBit = (r_bitCnt == LAST_BIT);
  assign w_bit         = (r_samples[0] & r_samples[1]) |
                         (r_samples[0] & r_samples[2]) |
                         (r_samples[1] & r_samples[2]);
  assign w_detect      = (r_state == IDLE) && !i_rx_in;
  assign w_capPrescale = ((i_prescale == 6'd16) || (i_prescale == 6'd32)) ?
                         i_prescale : 6'd8;
  assign w_parityBad   = ((^r_shift) ^ r_parTyp) != w_bit;

  // Frame sequencing. A start bit that does not hold low through its
  // sampling window is treated as a line glitch and the receiver goes back
  // to waiting. The parity state is skipped entirely when parity is off.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!i_rx_in) w_nextState = START;
      START:   if (w_lastEdge) w_nextState = w_bit ? IDLE : DATA;
      DATA:    if (w_lastEdge && w_lastDataBit) w_nextState = r_parEn ? PARITY : STOP;
      PARITY:  if (w_lastEdge) w_nextState = STOP;
      STOP:    if (w_lastEdge) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Edge counter. The detection cycle itself is edge 0 of the start bit, so
  // the counter leaves IDLE already pointing at edge 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_edgeCnt <= '0;
    end else if (r_state == IDLE) begin
      r_edgeCnt <= {5'd0, ~i_rx_in};
    end else if (w_lastEdge) begin
      r_edgeCnt <= '0;
    end else begin
      r_edgeCnt <= r_edgeCnt + 6'd1;
    end
  end

  // Data bit counter, only meaningful while in DATA.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bitCnt <= '0;
    end else if (r_state != DATA) begin
      r_bitCnt <= '0;
    end else if (w_lastEdge) begin
      r_bitCnt <= w_lastDataBit ? '0 : r_bitCnt + 1'b1;
    end
  end

  // Frame configuration is frozen at detection so that the inputs may change
  // freely while a frame is in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prescale <= 6'd8;
      r_parEn    <= 1'b0;
      r_parTyp   <= 1'b0;
    end else if (w_detect) begin
      r_prescale <= w_capPrescale;
      r_parEn    <= i_par_en;
      r_parTyp   <= i_par_typ;
    end
  end

  // Mid-bit sampler feeding the majority vote.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_samples <= '0;
    end else if ((r_state != IDLE) && w_inWindow) begin
      r_samples <= {r_samples[1:0], i_rx_in};
    end
  end

  // Data shift register (first bit on the line ends up in bit 0) and the
  // parity check, which is latched until the stop bit is evaluated.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift  <= '0;
      r_parErr <= 1'b0;
    end else begin
      if ((r_state == DATA) && w_lastEdge) begin
        r_shift <= {w_bit, r_shift[WIDTH-1:1]};
      end
      if (w_detect) begin
        r_parErr <= 1'b0;
      end else if ((r_state == PARITY) && w_lastEdge) begin
        r_parErr <= w_parityBad;
      end
    end
  end

  // Result stage. Pulses are cleared every cycle and raised only at the last
  // edge of the stop bit; the output word is updated for good frames only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_p_data     <= '0;
      o_data_valid <= 1'b0;
      o_par_err    <= 1'b0;
      o_stp_err    <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_par_err    <= 1'b0;
      o_stp_err    <= 1'b0;
      if ((r_state == STOP) && w_lastEdge) begin
        o_par_err <= r_parErr;
        o_stp_err <= ~w_bit;
        if (!r_parErr && w_bit) begin
          o_data_valid <= 1'b1;
          o_p_data     <= r_shift;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx. Frames are serialised by applyStimulus,
//   which pushes the expected result (cycle, pulses, output word) into a
//   scoreboard queue; a monitor on the falling edge pops and compares every
//   result pulse and flags results that never arrive.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             rxIn;
  logic [5:0]       prescale;
  logic             parEn;
  logic             parTyp;
  logic [WIDTH-1:0] pData;
  logic             dataValid;
  logic             parErr;
  logic             stpErr;

  int cycleCnt = 0;
  int nApplied = 0;
  int nFail    = 0;

  typedef struct {
    int         id;
    int         cyc;
    logic       valid;
    logic       parErr;
    logic       stpErr;
    logic [7:0] pdata;
  } sbEntry_t;

  typedef struct {
    logic [5:0] prescale;
    logic       parEn;
    logic       parTyp;
    logic [7:0] data;
    logic       parFlip;
    logic       stopBit;
    logic       glitch;
    logic       expValid;
    logic       expParErr;
    logic       expStpErr;
    logic [7:0] expPdata;
  } vector_t;

  sbEntry_t sbQueue[$];
  sbEntry_t monEntry;
  vector_t  vecs[8];
  int       frameId = 0;

  uart_rx #(.WIDTH(WIDTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_in      (rxIn),
    .i_prescale   (prescale),
    .i_par_en     (parEn),
    .i_par_typ    (parTyp),
    .o_p_data     (pData),
    .o_data_valid (dataValid),
    .o_par_err    (parErr),
    .o_stp_err    (stpErr)
  );

  // Free-running clock and cycle index (cycle index = posedges seen so far).
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // One comparison, counted, with a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    nApplied++;
    if (actual !== required) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Serialise one frame starting in the current cycle (called #1 after a
  // rising edge). The frame configuration is scrambled right after the
  // detection cycle so that a receiver that does not hold it would misdecode.
  task automatic applyStimulus(input logic [5:0] ps, input logic pe, input logic pt,
                               input logic [7:0] data, input logic parFlip,
                               input logic stopBit, input logic glitch,
                               input logic expValid, input logic expParErr,
                               input logic expStpErr, input logic [7:0] expPdata);
    int         p;
    int         nBits;
    logic [11:0] bits;
    logic       v;
    sbEntry_t   e;
    p     = ((ps == 6'd16) || (ps == 6'd32)) ? int'(ps) : 8;
    nBits = WIDTH + 2 + int'(pe);
    bits  = '0;
    for (int i = 0; i < WIDTH; i++) bits[i+1] = data[i];
    if (pe) bits[WIDTH+1] = (^data) ^ pt ^ parFlip;
    bits[nBits-1] = stopBit;
    prescale = ps;
    parEn    = pe;
    parTyp   = pt;
    e.id     = frameId;
    e.cyc    = cycleCnt + nBits * p;
    e.valid  = expValid;
    e.parErr = expParErr;
    e.stpErr = expStpErr;
    e.pdata  = expPdata;
    sbQueue.push_back(e);
    frameId++;
    for (int b = 0; b < nBits; b++) begin
      for (int k = 0; k < p; k++) begin
        v = bits[b];
        if (glitch && (b > 0) && ((k == 1) || (k == p - 2))) v = ~v;
        rxIn = v;
        if ((b == 0) && (k == 1)) begin
          prescale = (p == 8) ? 6'd16 : 6'd8;
          parEn    = ~pe;
          parTyp   = ~pt;
        end
        @(posedge clk);
        #1;
      end
    end
    rxIn = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    rxIn = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every result pulse must match the oldest pending
  // expectation, including the exact cycle; a pending expectation whose
  // cycle has passed is reported as missing.
  always @(negedge clk) begin
    if (!rst) begin
      if ((sbQueue.size() > 0) && (cycleCnt > sbQueue[0].cyc)) begin
        nApplied++;
        nFail++;
        $display("[TB] FAIL frame%0d missing: no result pulse by cycle %0d, expected at cycle %0d",
                 sbQueue[0].id, cycleCnt, sbQueue[0].cyc);
        void'(sbQueue.pop_front());
      end
      if (dataValid || parErr || stpErr) begin
        if (sbQueue.size() == 0) begin
          nApplied++;
          nFail++;
          $display("[TB] FAIL unexpected pulse at cycle %0d: got valid=%0b par=%0b stp=%0b, expected none",
                   cycleCnt, dataValid, parErr, stpErr);
        end else begin
          monEntry = sbQueue.pop_front();
          checkOutput($sformatf("frame%0d cycle", monEntry.id), cycleCnt, monEntry.cyc);
          checkOutput($sformatf("frame%0d valid", monEntry.id), {31'd0, dataValid}, {31'd0, monEntry.valid});
          checkOutput($sformatf("frame%0d parErr", monEntry.id), {31'd0, parErr}, {31'd0, monEntry.parErr});
          checkOutput($sformatf("frame%0d stpErr", monEntry.id), {31'd0, stpErr}, {31'd0, monEntry.stpErr});
          checkOutput($sformatf("frame%0d pdata", monEntry.id), {24'd0, pData}, {24'd0, monEntry.pdata});
        end
      end
    end
  end

  // Main sequence: reset, table of frames, then hand-written corner cases.
  initial begin
    //            ps     pe    pt    data   flip  stop  glit  val   perr  serr  pdata
    vecs[0] = '{6'd8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{6'd32, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{6'd8,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{6'd16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[4] = '{6'd10, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[5] = '{6'd32, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[6] = '{6'd16, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[7] = '{6'd8,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};

    rst      = 1'b1;
    rxIn     = 1'b1;
    prescale = 6'd8;
    parEn    = 1'b0;
    parTyp   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pdata", {24'd0, pData}, 32'd0);
    checkOutput("reset valid", {31'd0, dataValid}, 32'd0);
    checkOutput("reset parErr", {31'd0, parErr}, 32'd0);
    checkOutput("reset stpErr", {31'd0, stpErr}, 32'd0);
    rst = 1'b0;
    idleCycles(4);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].prescale, vecs[i].parEn, vecs[i].parTyp, vecs[i].data,
                    vecs[i].parFlip, vecs[i].stopBit, vecs[i].glitch,
                    vecs[i].expValid, vecs[i].expParErr, vecs[i].expStpErr,
                    vecs[i].expPdata);
      idleCycles(3);
    end

    // Start-bit glitch at P=16: low for 3 cycles only. The receiver must be
    // idle again in cycle 16, proven by a frame detected in exactly that cycle.
    prescale = 6'd16;
    parEn    = 1'b0;
    rxIn     = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rxIn = 1'b1;
    repeat (13) begin
      @(posedge clk);
      #1;
    end
    checkOutput("glitch pdata held", {24'd0, pData}, 32'h0000_00FF);
    applyStimulus(6'd8, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
    idleCycles(3);

    // Back-to-back frames at P=16 with no idle cycle between them.
    applyStimulus(6'd16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
    applyStimulus(6'd16, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
    idleCycles(3);

    // Reset during data bit 3 of a P=8 frame: no pulse, output word cleared.
    prescale = 6'd8;
    parEn    = 1'b0;
    rxIn     = 1'b0;
    repeat (8 + 3 * 8 + 4) begin
      @(posedge clk);
      #1;
    end
    rst  = 1'b1;
    rxIn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid-frame reset pdata", {24'd0, pData}, 32'd0);
    checkOutput("mid-frame reset valid", {31'd0, dataValid}, 32'd0);
    rst = 1'b0;
    idleCycles(2);
    applyStimulus(6'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81);

    idleCycles(20);
    checkOutput("scoreboard drained", sbQueue.size(), 32'd0);
    checkOutput("final pdata held", {24'd0, pData}, 32'h0000_0081);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    nFail++;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, limit 1000000", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame.
REQ-002 CLK  input  1  oversampling clock; one CLK cycle = one sample tick; sole clock of the block.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 RX_IN  input  1  serial line; idle high; already synchronised to CLK.
REQ-005 Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 PAR_EN  input  1  1 = parity bit present between data and stop.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 P_DATA  output  WIDTH  last correctly received byte, LSB = first data bit on line.
REQ-009 Data_Valid  output  1  one-cycle pulse: P_DATA holds a new good frame.
REQ-010 Par_Err  output  1  one-cycle pulse: parity mismatch in the frame just ended.
REQ-011 Stp_Err  output  1  one-cycle pulse: stop bit sampled 0.

Function
REQ-012 Frame = start(0), WIDTH data bits LSB first, optional parity, stop(1); N = WIDTH + 2 + PAR_EN bits.
REQ-013 FSM states IDLE, START, DATA, PARITY, STOP; PARITY visited only when PAR_EN = 1.
REQ-014 IDLE: a cycle with RX_IN = 0 is detection cycle (edge 0 of start bit); next state START.
REQ-015 Prescale, PAR_EN, PAR_TYP captured in the detection cycle and held for the whole frame; Prescale not in {8,16,32} treated as 8.
REQ-016 Edge counter counts 0..P-1 per bit (P = captured prescale), wraps to 0 and advances bit counter at P-1.
REQ-017 Each bit value = majority of RX_IN at edges P/2-1, P/2, P/2+1 (8: 3,4,5; 16: 7,8,9; 32: 15,16,17).
REQ-018 START decision at edge P-1: majority 1 -> glitch, return to IDLE, no output pulses; majority 0 -> DATA.
REQ-019 DATA: WIDTH bits shifted into an internal register LSB first; after bit WIDTH-1 -> PARITY or STOP.
REQ-020 PARITY: error when (XOR of data bits XOR PAR_TYP) differs from sampled parity bit.
REQ-021 STOP: at edge P-1 of stop bit, frame result registered; next cycle FSM in IDLE.
REQ-022 Result outputs asserted in the cycle N*P counted from detection cycle = 0, for exactly one cycle.
REQ-023 Good frame (no parity error, stop = 1): Data_Valid = 1, P_DATA loaded in the same cycle.
REQ-024 Bad frame: Data_Valid = 0, P_DATA unchanged, Par_Err and/or Stp_Err pulsed; both may pulse together.
REQ-025 P_DATA holds its value between frames; changes only with Data_Valid.
REQ-026 Back-to-back frames: RX_IN = 0 in the first IDLE cycle after STOP is a new detection cycle; no dead cycles beyond that.
REQ-027 RX_IN changes mid-bit outside the sampling window have no effect on the decoded bit.

Reset
REQ-028 RST = 1 at a CLK edge: state IDLE, edge/bit counters 0, shift register 0, P_DATA = 0, Data_Valid = Par_Err = Stp_Err = 0.
REQ-029 RST mid-frame aborts the frame with no output pulse; reception restarts on the first RX_IN = 0 seen in IDLE after RST deasserts.
REQ-030 RST has priority over all other inputs in the same cycle.

Verification
REQ-031 P=8, PAR_EN=1, PAR_TYP=0, send 0xA5 (parity 0, stop 1) -> Data_Valid pulse at cycle 88, P_DATA = 0xA5, no errors.
REQ-032 P=16, PAR_EN=0, RX_IN low 3 cycles then high -> FSM back to IDLE after edge 15, no pulses, P_DATA unchanged.
REQ-033 P=32, PAR_EN=1, PAR_TYP=1, send 0x0F with parity bit 0 -> Par_Err pulse at cycle 352, Data_Valid 0, P_DATA unchanged.
REQ-034 P=8, PAR_EN=0, send 0x3C with stop bit 0 -> Stp_Err pulse at cycle 80, Data_Valid 0.
REQ-035 P=16, PAR_EN=0, frames 0x55 then 0xAA back-to-back -> Data_Valid at cycles 160 and 320, P_DATA 0x55 then 0xAA.
REQ-036 RST pulsed during DATA bit 3 of a frame, then 0x81 sent at P=8, PAR_EN=0 -> no pulse for the aborted frame; Data_Valid with P_DATA = 0x81 at cycle 80 of the new frame.
